prog_loader: RTL and testbench

- Byte-stream program loader directly upstream of the CPU core.
- Accepts a framed program image over a valid/ready byte interface and writes it into op RAM through the core's write/writeop/addr load port.
- Holds the core in reset until a complete, checksum-verified image has been loaded.

---
 rtl/prog_loader.sv | 127 ++++++++++++
 tb/tb_prog_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream program loader placed in front of the CPU core.
// It receives a framed image as SYNC_BYTE, LEN, LEN+1 data bytes, CSUM, and
// writes each data byte into op RAM through the core's load port. The core is
// held in reset until a frame with a good checksum has been loaded.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   in_valid/in_data  upstream byte stream; a byte moves when in_valid & in_ready
//   in_ready          high in every state except ERR
//   err_clr           single-cycle pulse that leaves ERR
//   write/writeop/addr  op RAM load port, registered (1-cycle latency)
//   cpu_rst           core reset, released only while a verified image is loaded
//   busy/done/error   frame in progress / image loaded / frame rejected
module prog_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              err_clr,
    output logic              write,
    output logic [7:0]        writeop,
    output logic [ADDR_W-1:0] addr,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {StIdle, StLen, StData, StCsum, StDone, StErr} state_t;

    state_t            state_q, state_d;
    logic [7:0]        remaining_q, remaining_d;
    logic [7:0]        sum_q, sum_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic              write_q, write_d;
    logic [7:0]        writeop_q, writeop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic       xfer;
    logic [7:0] csum_total;

    assign xfer       = in_valid & in_ready;
    assign csum_total = sum_q + in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            remaining_q <= 8'd0;
            sum_q       <= 8'd0;
            index_q     <= '0;
            write_q     <= 1'b0;
            writeop_q   <= 8'd0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            sum_q       <= sum_d;
            index_q     <= index_d;
            write_q     <= write_d;
            writeop_q   <= writeop_d;
            addr_q      <= addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        sum_d       = sum_q;
        index_d     = index_q;
        write_d     = 1'b0;
        writeop_d   = writeop_q;
        addr_d      = addr_q;

        unique case (state_q)
            StIdle: begin
                if (xfer && in_data == SYNC_BYTE) state_d = StLen;
            end
            StLen: begin
                if (xfer) begin
                    remaining_d = in_data;
                    sum_d       = 8'd0;
                    index_d     = '0;
                    state_d     = StData;
                end
            end
            StData: begin
                if (xfer) begin
                    write_d   = 1'b1;
                    writeop_d = in_data;
                    addr_d    = index_q;
                    sum_d     = sum_q + in_data;
                    // Wraps to 0 only after the last byte of a 256-byte frame.
                    index_d   = index_q + 1'b1;
                    if (remaining_q == 8'd0) state_d = StCsum;
                    else remaining_d = remaining_q - 8'd1;
                end
            end
            StCsum: begin
                if (xfer) state_d = (csum_total == 8'd0) ? StDone : StErr;
            end
            StDone: begin
                // A new sync byte starts a reload and puts the core back in reset.
                if (xfer && in_data == SYNC_BYTE) state_d = StLen;
            end
            StErr: begin
                if (err_clr) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Status outputs decode the registered state, so they change on the same
    // edge that moves the FSM.
    assign in_ready = (state_q != StErr);
    assign busy     = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
    assign done     = (state_q == StDone);
    assign error    = (state_q == StErr);
    assign cpu_rst  = (state_q != StDone);
    assign write    = write_q;
    assign writeop  = writeop_q;
    assign addr     = addr_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table-driven byte vectors plus
// hand-written sequences for bubbles, the 256-byte frame and mid-frame reset.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic       err_clr = 1'b0;
    logic       write;
    logic [7:0] writeop;
    logic [7:0] addr;
    logic       cpu_rst;
    logic       busy;
    logic       done;
    logic       error;

    int n_total = 0;
    int n_pass  = 0;

    prog_loader #(
        .SYNC_BYTE(8'hA5),
        .ADDR_W   (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .err_clr (err_clr),
        .write   (write),
        .writeop (writeop),
        .addr    (addr),
        .cpu_rst (cpu_rst),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       wr;
        logic [7:0] adr;
        logic [7:0] op;
        logic       bsy;
        logic       dn;
        logic       err;
        logic       crst;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [7:0] d, logic w, logic [7:0] a, logic [7:0] o,
                                logic b, logic dn, logic e, logic c, logic r);
        vec_t v;
        v.data = d; v.wr = w; v.adr = a; v.op = o;
        v.bsy = b; v.dn = dn; v.err = e; v.crst = c; v.rdy = r;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // One-cycle transfer; returns #1 after the edge so registered outputs are visible.
    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic apply_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        send(v.data);
        chk($sformatf("v%0d write", idx), write, v.wr);
        if (v.wr) begin
            chk($sformatf("v%0d addr", idx), addr, v.adr);
            chk($sformatf("v%0d writeop", idx), writeop, v.op);
        end
        chk($sformatf("v%0d busy", idx), busy, v.bsy);
        chk($sformatf("v%0d done", idx), done, v.dn);
        chk($sformatf("v%0d error", idx), error, v.err);
        chk($sformatf("v%0d cpu_rst", idx), cpu_rst, v.crst);
        chk($sformatf("v%0d in_ready", idx), in_ready, v.rdy);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " write"}, write, 1'b0);
        chk({tag, " writeop"}, writeop, 8'h00);
        chk({tag, " addr"}, addr, 8'h00);
        chk({tag, " cpu_rst"}, cpu_rst, 1'b1);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " done"}, done, 1'b0);
        chk({tag, " error"}, error, 1'b0);
        chk({tag, " in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        //                data  wr adr    op     bsy dn err crst rdy
        // 0-5: good frame, 0x10+0x21+0x32 = 0x63, csum 0x9D
        vecs.push_back(mk(8'hA5, 0, 8'h00, 8'h00, 1, 0, 0, 1, 1));
        vecs.push_back(mk(8'h02, 0, 8'h00, 8'h00, 1, 0, 0, 1, 1));
        vecs.push_back(mk(8'h10, 1, 8'h00, 8'h10, 1, 0, 0, 1, 1));
        vecs.push_back(mk(8'h21, 1, 8'h01, 8'h21, 1, 0, 0, 1, 1));
        vecs.push_back(mk(8'h32, 1, 8'h02, 8'h32, 1, 0, 0, 1, 1));
        vecs.push_back(mk(8'h9D, 0, 8'h00, 8'h00, 0, 1, 0, 0, 1));
        // 6-11: same frame, bad csum (reload from DONE)
        vecs.push_back(mk(8'hA5, 0, 8'h00, 8'h00, 1, 0, 0, 1, 1));
        vecs.push_back(mk(8'h02, 0, 8'h00, 8'h00, 1, 0, 0, 1, 1));
        vecs.push_back(mk(8'h10, 1, 8'h00, 8'h10, 1, 0, 0, 1, 1));
        vecs.push_back(mk(8'h21, 1, 8'h01, 8'h21, 1, 0, 0, 1, 1));
        vecs.push_back(mk(8'h32, 1, 8'h02, 8'h32, 1, 0, 0, 1, 1));
        vecs.push_back(mk(8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 1, 0));
        // 12-17: leading junk, then LEN=0 frame with 0x7F, csum 0x81
        vecs.push_back(mk(8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 1, 1));
        vecs.push_back(mk(8'hFF, 0, 8'h00, 8'h00, 0, 0, 0, 1, 1));
        vecs.push_back(mk(8'hA5, 0, 8'h00, 8'h00, 1, 0, 0, 1, 1));
        vecs.push_back(mk(8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 1, 1));
        vecs.push_back(mk(8'h7F, 1, 8'h00, 8'h7F, 1, 0, 0, 1, 1));
        vecs.push_back(mk(8'h81, 0, 8'h00, 8'h00, 0, 1, 0, 0, 1));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;

        // Scenarios 1 and 2
        for (int i = 0; i < 12; i++) apply_vec(i);

        // Bytes offered in ERR are not accepted and cause no write.
        send(8'hA5);
        chk("err hold error", error, 1'b1);
        chk("err hold write", write, 1'b0);
        chk("err hold ready", in_ready, 1'b0);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("err_clr error", error, 1'b0);
        chk("err_clr ready", in_ready, 1'b1);
        chk("err_clr cpu_rst", cpu_rst, 1'b1);
        chk("err_clr busy", busy, 1'b0);

        // Scenario 3
        for (int i = 12; i < 18; i++) apply_vec(i);

        // Scenario 4: 256-byte frame, bytes 0..255, sum 0x80, csum 0x80
        send(8'hA5);
        send(8'hFF);
        chk("big busy", busy, 1'b1);
        for (int i = 0; i < 256; i++) begin
            send(i[7:0]);
            chk($sformatf("big write %0d", i), write, 1'b1);
            chk($sformatf("big addr %0d", i), addr, i[7:0]);
            chk($sformatf("big op %0d", i), writeop, i[7:0]);
        end
        send(8'h80);
        chk("big csum write", write, 1'b0);
        chk("big done", done, 1'b1);
        chk("big cpu_rst", cpu_rst, 1'b0);
        chk("big addr hold", addr, 8'hFF);

        // Scenario 5: scenario 1 frame with 3-cycle bubbles between bytes
        for (int i = 0; i < 6; i++) begin
            apply_vec(i);
            for (int g = 0; g < 3; g++) begin
                @(posedge clk);
                #1;
                chk($sformatf("gap%0d.%0d write", i, g), write, 1'b0);
                chk($sformatf("gap%0d.%0d busy", i, g), busy, vecs[i].bsy);
                chk($sformatf("gap%0d.%0d done", i, g), done, vecs[i].dn);
            end
        end

        // Scenario 6: reload puts core back in reset, then async reset mid-DATA
        send(8'hA5);
        chk("reload cpu_rst", cpu_rst, 1'b1);
        chk("reload done", done, 1'b0);
        chk("reload busy", busy, 1'b1);
        send(8'h02);
        send(8'h10);
        chk("mid write", write, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Abandoned frame: a non-sync byte is discarded in IDLE.
        send(8'h21);
        chk("post rst busy", busy, 1'b0);
        chk("post rst write", write, 1'b0);
        send(8'hA5);
        chk("post rst sync busy", busy, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
